// File: rtl/dpram_be.sv
// True dual-port synchronous RAM with byte-lane enables, read-first semantics,
// port-0-priority write/write collision merge and a selectable read latency of 1 or 2.
module dpram_be #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned READ_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_0,
    input  logic                  we_0,
    input  logic [DATA_W/8-1:0]   be_0,
    input  logic [ADDR_W-1:0]     addr_0,
    input  logic [DATA_W-1:0]     wdata_0,
    output logic [DATA_W-1:0]     rdata_0,
    output logic                  rvalid_0,
    output logic                  wack_0,
    input  logic                  req_1,
    input  logic                  we_1,
    input  logic [DATA_W/8-1:0]   be_1,
    input  logic [ADDR_W-1:0]     addr_1,
    input  logic [DATA_W-1:0]     wdata_1,
    output logic [DATA_W-1:0]     rdata_1,
    output logic                  rvalid_1,
    output logic                  wack_1,
    output logic                  coll
);

    localparam int unsigned LANES = DATA_W / 8;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_wr_0;
    logic              w_wr_1;
    logic              w_rd_0;
    logic              w_rd_1;
    logic              w_same;
    logic [LANES-1:0]  w_be_1;
    logic              w_coll_hit;

    logic [DATA_W-1:0] r_s1_data_0;
    logic [DATA_W-1:0] r_s1_data_1;
    logic              r_s1_vld_0;
    logic              r_s1_vld_1;
    logic              r_wack_0;
    logic              r_wack_1;
    logic              r_coll;

    assign w_wr_0 = req_0 & we_0 & ~reset;
    assign w_wr_1 = req_1 & we_1 & ~reset;
    assign w_rd_0 = req_0 & ~we_0 & ~reset;
    assign w_rd_1 = req_1 & ~we_1 & ~reset;

    // Port 0 wins a same-address write, so port 1 loses every lane port 0 also enables.
    assign w_same     = w_wr_0 & w_wr_1 & (addr_0 == addr_1);
    assign w_be_1     = be_1 & ~({LANES{w_same}} & be_0);
    assign w_coll_hit = w_same & (|(be_0 & be_1));

    // Storage: per-lane writes, no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (w_wr_0 && be_0[i]) r_mem[addr_0][8*i +: 8] <= wdata_0[8*i +: 8];
            if (w_wr_1 && w_be_1[i]) r_mem[addr_1][8*i +: 8] <= wdata_1[8*i +: 8];
        end
    end

    // First read stage, write acks and the sticky collision flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_data_0 <= '0;
            r_s1_data_1 <= '0;
            r_s1_vld_0  <= 1'b0;
            r_s1_vld_1  <= 1'b0;
            r_wack_0    <= 1'b0;
            r_wack_1    <= 1'b0;
            r_coll      <= 1'b0;
        end else begin
            if (w_rd_0) r_s1_data_0 <= r_mem[addr_0];
            if (w_rd_1) r_s1_data_1 <= r_mem[addr_1];
            r_s1_vld_0 <= w_rd_0;
            r_s1_vld_1 <= w_rd_1;
            r_wack_0   <= w_wr_0;
            r_wack_1   <= w_wr_1;
            r_coll     <= r_coll | w_coll_hit;
        end
    end

    assign wack_0 = r_wack_0;
    assign wack_1 = r_wack_1;
    assign coll   = r_coll;

    // Any READ_LAT other than 2 is treated as a single-cycle read.
    if (READ_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] r_s2_data_0;
        logic [DATA_W-1:0] r_s2_data_1;
        logic              r_s2_vld_0;
        logic              r_s2_vld_1;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_s2_data_0 <= '0;
                r_s2_data_1 <= '0;
                r_s2_vld_0  <= 1'b0;
                r_s2_vld_1  <= 1'b0;
            end else begin
                if (r_s1_vld_0) r_s2_data_0 <= r_s1_data_0;
                if (r_s1_vld_1) r_s2_data_1 <= r_s1_data_1;
                r_s2_vld_0 <= r_s1_vld_0;
                r_s2_vld_1 <= r_s1_vld_1;
            end
        end

        assign rdata_0  = r_s2_data_0;
        assign rdata_1  = r_s2_data_1;
        assign rvalid_0 = r_s2_vld_0;
        assign rvalid_1 = r_s2_vld_1;
    end else begin : g_lat1
        assign rdata_0  = r_s1_data_0;
        assign rdata_1  = r_s1_data_1;
        assign rvalid_0 = r_s1_vld_0;
        assign rvalid_1 = r_s1_vld_1;
    end

endmodule

// File: tb/tb_dpram_be.sv
// Directed bench for dpram_be: a 16-bit/1-cycle instance and a 32-bit/16-word/2-cycle
// instance, with read expectations queued at issue time and checked when rvalid arrives.
module tb_dpram_be;

    typedef struct {
        logic [31:0] data;
        int          due;
    } sb_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: 16-bit data, 16-bit address, READ_LAT=1
    logic        a_req0 = 0, a_we0 = 0, a_req1 = 0, a_we1 = 0;
    logic [1:0]  a_be0 = 0, a_be1 = 0;
    logic [15:0] a_addr0 = 0, a_addr1 = 0, a_wd0 = 0, a_wd1 = 0;
    logic [15:0] a_rd0, a_rd1;
    logic        a_rv0, a_rv1, a_wk0, a_wk1, a_coll;

    // Instance B: 32-bit data, 4-bit address, READ_LAT=2
    logic        b_req0 = 0, b_we0 = 0, b_req1 = 0, b_we1 = 0;
    logic [3:0]  b_be0 = 0, b_be1 = 0;
    logic [3:0]  b_addr0 = 0, b_addr1 = 0;
    logic [31:0] b_wd0 = 0, b_wd1 = 0;
    logic [31:0] b_rd0, b_rd1;
    logic        b_rv0, b_rv1, b_wk0, b_wk1, b_coll;

    sb_t qa0[$], qa1[$], qb0[$], qb1[$];

    dpram_be #(.DATA_W(16), .ADDR_W(16), .READ_LAT(1)) u_a (
        .clk(clk), .reset(reset),
        .req_0(a_req0), .we_0(a_we0), .be_0(a_be0), .addr_0(a_addr0), .wdata_0(a_wd0),
        .rdata_0(a_rd0), .rvalid_0(a_rv0), .wack_0(a_wk0),
        .req_1(a_req1), .we_1(a_we1), .be_1(a_be1), .addr_1(a_addr1), .wdata_1(a_wd1),
        .rdata_1(a_rd1), .rvalid_1(a_rv1), .wack_1(a_wk1),
        .coll(a_coll)
    );

    dpram_be #(.DATA_W(32), .ADDR_W(4), .READ_LAT(2)) u_b (
        .clk(clk), .reset(reset),
        .req_0(b_req0), .we_0(b_we0), .be_0(b_be0), .addr_0(b_addr0), .wdata_0(b_wd0),
        .rdata_0(b_rd0), .rvalid_0(b_rv0), .wack_0(b_wk0),
        .req_1(b_req1), .we_1(b_we1), .be_1(b_be1), .addr_1(b_addr1), .wdata_1(b_wd1),
        .rdata_1(b_rd1), .rvalid_1(b_rv1), .wack_1(b_wk1),
        .coll(b_coll)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one access on instance A; for a read, d is the data the read must return.
    task automatic a_op(input int p, input logic we, input logic [1:0] be,
                        input logic [15:0] addr, input logic [15:0] d);
        sb_t e;
        e.data = 32'(d);
        e.due  = cyc + 1;
        if (p == 0) begin
            a_req0 = 1; a_we0 = we; a_be0 = be; a_addr0 = addr; a_wd0 = d;
            if (!we) qa0.push_back(e);
        end else begin
            a_req1 = 1; a_we1 = we; a_be1 = be; a_addr1 = addr; a_wd1 = d;
            if (!we) qa1.push_back(e);
        end
    endtask

    task automatic b_op(input int p, input logic we, input logic [3:0] be,
                        input logic [3:0] addr, input logic [31:0] d);
        sb_t e;
        e.data = d;
        e.due  = cyc + 2;
        if (p == 0) begin
            b_req0 = 1; b_we0 = we; b_be0 = be; b_addr0 = addr; b_wd0 = d;
            if (!we) qb0.push_back(e);
        end else begin
            b_req1 = 1; b_we1 = we; b_be1 = be; b_addr1 = addr; b_wd1 = d;
            if (!we) qb1.push_back(e);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        a_req0 = 0; a_req1 = 0; b_req0 = 0; b_req1 = 0;
    endtask

    // Read-return monitors: every rvalid must match the oldest queued read, on its due cycle.
    always @(negedge clk) begin : m_a0
        sb_t e;
        if (a_rv0 === 1'b1) begin
            if (qa0.size() == 0) chk("a0 unexpected rvalid", 32'd1, 32'd0);
            else begin
                e = qa0.pop_front();
                chk("a0 rdata", 32'(a_rd0), e.data);
                chk("a0 latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    always @(negedge clk) begin : m_a1
        sb_t e;
        if (a_rv1 === 1'b1) begin
            if (qa1.size() == 0) chk("a1 unexpected rvalid", 32'd1, 32'd0);
            else begin
                e = qa1.pop_front();
                chk("a1 rdata", 32'(a_rd1), e.data);
                chk("a1 latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    always @(negedge clk) begin : m_b0
        sb_t e;
        if (b_rv0 === 1'b1) begin
            if (qb0.size() == 0) chk("b0 unexpected rvalid", 32'd1, 32'd0);
            else begin
                e = qb0.pop_front();
                chk("b0 rdata", b_rd0, e.data);
                chk("b0 latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    always @(negedge clk) begin : m_b1
        sb_t e;
        if (b_rv1 === 1'b1) begin
            if (qb1.size() == 0) chk("b1 unexpected rvalid", 32'd1, 32'd0);
            else begin
                e = qb1.pop_front();
                chk("b1 rdata", b_rd1, e.data);
                chk("b1 latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    initial begin
        reset = 1;
        tick; tick;
        reset = 0;

        // Reset with traffic: preload, then a write and a read presented under reset
        a_op(0, 1, 2'b11, 16'h0010, 16'h1234);
        tick;
        chk("preload wack_0", 32'(a_wk0), 32'd1);
        reset = 1;
        a_op(0, 1, 2'b11, 16'h0010, 16'hBEEF);
        a_req1 = 1; a_we1 = 0; a_addr1 = 16'h0010;
        tick;
        reset = 0;
        chk("reset wack_0", 32'(a_wk0), 32'd0);
        chk("reset rvalid_0", 32'(a_rv0), 32'd0);
        chk("reset rvalid_1", 32'(a_rv1), 32'd0);
        chk("reset coll", 32'(a_coll), 32'd0);
        chk("reset rdata_0", 32'(a_rd0), 32'd0);
        a_op(0, 0, 2'b00, 16'h0010, 16'h1234);
        tick; tick;

        // Byte-lane write
        a_op(0, 1, 2'b11, 16'h0100, 16'hAAAA);
        tick;
        chk("lane wack_0 #1", 32'(a_wk0), 32'd1);
        a_op(0, 1, 2'b01, 16'h0100, 16'h55CC);
        tick;
        chk("lane wack_0 #2", 32'(a_wk0), 32'd1);
        a_op(0, 0, 2'b00, 16'h0100, 16'hAACC);
        tick;
        chk("read no wack_0", 32'(a_wk0), 32'd0);
        a_op(0, 1, 2'b11, 16'h0104, 16'hFFFF);
        tick; tick;
        chk("rdata_0 hold", 32'(a_rd0), 32'h0000AACC);
        chk("wack_0 single pulse", 32'(a_wk0), 32'd0);

        // Cross-port read-first
        a_op(1, 1, 2'b11, 16'h0200, 16'h1111);
        tick;
        a_op(0, 1, 2'b11, 16'h0200, 16'h2222);
        a_op(1, 0, 2'b00, 16'h0200, 16'h1111);
        tick;
        a_op(1, 0, 2'b00, 16'h0200, 16'h2222);
        tick; tick;

        // Simultaneous writes to different addresses with overlapping lanes
        a_op(0, 1, 2'b11, 16'h0500, 16'h5555);
        a_op(1, 1, 2'b11, 16'h0501, 16'h6666);
        tick;
        chk("diff addr coll", 32'(a_coll), 32'd0);
        a_op(0, 0, 2'b00, 16'h0501, 16'h6666);
        a_op(1, 0, 2'b00, 16'h0500, 16'h5555);
        tick; tick;

        // Write/write collision
        a_op(0, 1, 2'b10, 16'h0300, 16'hAB00);
        a_op(1, 1, 2'b11, 16'h0300, 16'h12CD);
        tick;
        chk("coll wack_0", 32'(a_wk0), 32'd1);
        chk("coll wack_1", 32'(a_wk1), 32'd1);
        chk("coll set", 32'(a_coll), 32'd1);
        a_op(1, 0, 2'b00, 16'h0300, 16'hABCD);
        tick;
        repeat (3) tick;
        chk("coll sticky", 32'(a_coll), 32'd1);
        reset = 1;
        tick;
        reset = 0;
        chk("coll cleared", 32'(a_coll), 32'd0);

        // Disjoint-lane same-address writes
        a_op(0, 1, 2'b10, 16'h0400, 16'hAB00);
        a_op(1, 1, 2'b01, 16'h0400, 16'h00CD);
        tick;
        chk("disjoint coll", 32'(a_coll), 32'd0);
        a_op(0, 0, 2'b00, 16'h0400, 16'hABCD);
        tick; tick;

        // Instance B: preload then pipelined back-to-back reads
        for (int i = 0; i < 4; i++) begin
            b_op(1, 1, 4'hF, 4'(i), 32'hA0 + 32'(i));
            tick;
        end
        for (int i = 0; i < 4; i++) begin
            b_op(1, 0, 4'h0, 4'(i), 32'hA0 + 32'(i));
            tick;
        end
        repeat (3) tick;
        chk("b rdata_1 hold", b_rd1, 32'h000000A3);
        chk("b rvalid_1 idle", 32'(b_rv1), 32'd0);

        // Top of address space, then address 0 untouched
        b_op(0, 1, 4'hF, 4'hF, 32'hDEADBEEF);
        tick;
        chk("b wack_0", 32'(b_wk0), 32'd1);
        b_op(0, 0, 4'h0, 4'hF, 32'hDEADBEEF);
        tick;
        b_op(0, 0, 4'h0, 4'h0, 32'h000000A0);
        tick;
        repeat (3) tick;

        // 32-bit byte lanes
        b_op(1, 1, 4'hF, 4'h5, 32'h11223344);
        tick;
        b_op(1, 1, 4'b0101, 4'h5, 32'hAABBCCDD);
        tick;
        b_op(1, 0, 4'h0, 4'h5, 32'h11BB33DD);
        tick;
        repeat (3) tick;

        // In-flight read dropped by reset
        b_req0 = 1; b_we0 = 0; b_addr0 = 4'h1;
        tick;
        reset = 1;
        tick;
        reset = 0;
        chk("b drop rvalid_0", 32'(b_rv0), 32'd0);
        chk("b drop rdata_0", b_rd0, 32'd0);
        repeat (3) tick;
        chk("b drop still quiet", 32'(b_rv0), 32'd0);

        repeat (4) tick;
        chk("qa0 drained", 32'(qa0.size()), 32'd0);
        chk("qa1 drained", 32'(qa1.size()), 32'd0);
        chk("qb0 drained", 32'(qb0.size()), 32'd0);
        chk("qb1 drained", 32'(qb1.size()), 32'd0);
        chk("b coll never set", 32'(b_coll), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
